// File: rtl/nested_bit_select_pkg.sv
// Shared types and helpers for nested_bit_select: range flags and index helpers.
package nested_bit_select_pkg;

  typedef struct packed {
    logic sub_oor;
    logic bit_oor;
  } range_flags_t;

  localparam int unsigned RangeFlagW = $bits(range_flags_t);

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_range(input int unsigned idx, input int unsigned lim);
    return idx < lim;
  endfunction

  // Inner bit index carried down the pipe; forced to 0 for out-of-range requests.
  function automatic int unsigned bit_index(input int unsigned idx, input logic oor);
    return oor ? 0 : idx;
  endfunction

endpackage

// File: rtl/nbs_stage.sv
// Generic valid/ready pipeline register; accepts whenever empty or draining.
module nbs_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         adv;

  always_comb begin
    adv     = !valid_q || ready_i;
    ready_o = adv;
    valid_d = adv ? valid_i : valid_q;
    data_d  = (adv && valid_i) ? data_i : data_q;
    valid_o = valid_q;
    data_o  = data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/nested_bit_select.sv
// Two-stage sub-word / bit selector with valid/ready flow control.
// Define NESTED_BIT_SELECT_RANGE_CHECK_EN to report out-of-range requests on out_err.
module nested_bit_select
  import nested_bit_select_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SUB_W = 4,
  localparam int unsigned NSUB = WIDTH / SUB_W,
  localparam int unsigned SI_W = idx_width(NSUB),
  localparam int unsigned BI_W = idx_width(SUB_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SI_W-1:0]  in_sub_idx,
  input  logic [BI_W-1:0]  in_bit_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUB_W-1:0] out_sub,
  output logic             out_bit,
  output logic             out_err
);

`ifdef NESTED_BIT_SELECT_RANGE_CHECK_EN
  localparam int unsigned FlagW = RangeFlagW;
  range_flags_t s1_flags_in, s1_flags;
`else
  localparam int unsigned FlagW = 0;
`endif
  localparam int unsigned S1W = SUB_W + BI_W + FlagW;
  localparam int unsigned S2W = SUB_W + 1 + (FlagW > 0 ? 1 : 0);

  logic [SUB_W-1:0] sel_sub, s1_sub;
  logic [BI_W-1:0]  s1_bit;
  logic             sub_ok, bit_ok, oor, s2_bit;
  logic [S1W-1:0]   s1_in, s1_out;
  logic [S2W-1:0]   s2_in, s2_out;
  logic             s1_valid, s2_ready;

  always_comb begin
    sel_sub = '0;
    for (int unsigned k = 0; k < NSUB; k++) begin
      if (32'(in_sub_idx) == k) sel_sub = in_data[k*SUB_W +: SUB_W];
    end
    sub_ok = in_range(32'(in_sub_idx), NSUB);
    bit_ok = in_range(32'(in_bit_idx), SUB_W);
    oor    = !(sub_ok && bit_ok);
`ifdef NESTED_BIT_SELECT_RANGE_CHECK_EN
    s1_flags_in = '{sub_oor: !sub_ok, bit_oor: !bit_ok};
    s1_in = {(oor ? '0 : sel_sub), BI_W'(bit_index(32'(in_bit_idx), oor)), s1_flags_in};
`else
    s1_in = {(oor ? '0 : sel_sub), BI_W'(bit_index(32'(in_bit_idx), oor))};
`endif
  end

  nbs_stage #(.W(S1W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  (s1_in),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_out)
  );

  // Out-of-range requests arrive with a zeroed sub-word and bit index, so the pick yields 0.
  always_comb begin
`ifdef NESTED_BIT_SELECT_RANGE_CHECK_EN
    {s1_sub, s1_bit, s1_flags} = s1_out;
`else
    {s1_sub, s1_bit} = s1_out;
`endif
    s2_bit = 1'b0;
    for (int unsigned k = 0; k < SUB_W; k++) begin
      if (32'(s1_bit) == k) s2_bit = s1_sub[k];
    end
`ifdef NESTED_BIT_SELECT_RANGE_CHECK_EN
    s2_in = {s1_sub, s2_bit, (s1_flags.sub_oor | s1_flags.bit_oor)};
`else
    s2_in = {s1_sub, s2_bit};
`endif
  end

  nbs_stage #(.W(S2W)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (s2_in),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (s2_out)
  );

  always_comb begin
`ifdef NESTED_BIT_SELECT_RANGE_CHECK_EN
    {out_sub, out_bit, out_err} = s2_out;
`else
    {out_sub, out_bit} = s2_out;
    out_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_nested_bit_select.sv
// Directed bench for nested_bit_select: 16/4, 12/4 and 8/1 configurations.
module tb_nested_bit_select;

`ifdef NESTED_BIT_SELECT_RANGE_CHECK_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 16/4 instance
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_bit, m_out_err;
  logic [15:0] m_in_data;
  logic [1:0]  m_in_sub_idx, m_in_bit_idx;
  logic [3:0]  m_out_sub;

  nested_bit_select #(.WIDTH(16), .SUB_W(4)) dut_m (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .in_sub_idx(m_in_sub_idx), .in_bit_idx(m_in_bit_idx), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_sub(m_out_sub), .out_bit(m_out_bit), .out_err(m_out_err)
  );

  // 12/4 instance: sub index 3 is out of range
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_bit, c_out_err;
  logic [11:0] c_in_data;
  logic [1:0]  c_in_sub_idx, c_in_bit_idx;
  logic [3:0]  c_out_sub;

  nested_bit_select #(.WIDTH(12), .SUB_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_sub_idx(c_in_sub_idx), .in_bit_idx(c_in_bit_idx), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_sub(c_out_sub), .out_bit(c_out_bit), .out_err(c_out_err)
  );

  // 8/1 instance: bit index 1 is out of range
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit, b_out_err;
  logic [7:0] b_in_data;
  logic [2:0] b_in_sub_idx;
  logic [0:0] b_in_bit_idx;
  logic [0:0] b_out_sub;

  nested_bit_select #(.WIDTH(8), .SUB_W(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sub_idx(b_in_sub_idx), .in_bit_idx(b_in_bit_idx), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sub(b_out_sub), .out_bit(b_out_bit), .out_err(b_out_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_c(input string name, input logic [11:0] d, input logic [1:0] s,
                       input logic [1:0] b, input logic [3:0] es, input logic eb,
                       input logic ee);
    c_in_valid = 1'b1; c_in_data = d; c_in_sub_idx = s; c_in_bit_idx = b;
    step();
    c_in_valid = 1'b0;
    step();
    chk({name, "_valid"}, 32'(c_out_valid), 32'd1);
    chk({name, "_sub"}, 32'(c_out_sub), 32'(es));
    chk({name, "_bit"}, 32'(c_out_bit), 32'(eb));
    chk({name, "_err"}, 32'(c_out_err), 32'(ee));
  endtask

  task automatic run_b(input string name, input logic [7:0] d, input logic [2:0] s,
                       input logic b, input logic es, input logic eb, input logic ee);
    b_in_valid = 1'b1; b_in_data = d; b_in_sub_idx = s; b_in_bit_idx = b;
    step();
    b_in_valid = 1'b0;
    step();
    chk({name, "_valid"}, 32'(b_out_valid), 32'd1);
    chk({name, "_sub"}, 32'(b_out_sub), 32'(es));
    chk({name, "_bit"}, 32'(b_out_bit), 32'(eb));
    chk({name, "_err"}, 32'(b_out_err), 32'(ee));
  endtask

  typedef struct {
    logic [15:0] data;
    logic [1:0]  sub;
    logic [1:0]  bi;
    logic [3:0]  esub;
    logic        ebit;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'habcd, 2'd2, 2'd3, 4'hb, 1'b1};
    vecs[1] = '{16'habcd, 2'd0, 2'd1, 4'hd, 1'b0};
    vecs[2] = '{16'habcd, 2'd3, 2'd3, 4'ha, 1'b1};
    vecs[3] = '{16'habcd, 2'd1, 2'd2, 4'hc, 1'b1};
    vecs[4] = '{16'h1234, 2'd1, 2'd0, 4'h3, 1'b1};
    vecs[5] = '{16'h1234, 2'd3, 2'd0, 4'h1, 1'b1};
    vecs[6] = '{16'h1234, 2'd2, 2'd2, 4'h2, 1'b0};

    rst = 1'b1;
    m_in_valid = 1'b0; m_in_data = '0; m_in_sub_idx = '0; m_in_bit_idx = '0; m_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_sub_idx = '0; c_in_bit_idx = '0; c_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_sub_idx = '0; b_in_bit_idx = '0; b_out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("rst_in_ready", 32'(m_in_ready), 32'd1);
    chk("rst_out_sub", 32'(m_out_sub), 32'd0);
    chk("rst_out_bit", 32'(m_out_bit), 32'd0);
    chk("rst_out_err", 32'(m_out_err), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Single requests, 2-cycle latency each
    for (int i = 0; i < 7; i++) begin
      m_in_valid = 1'b1;
      m_in_data = vecs[i].data; m_in_sub_idx = vecs[i].sub; m_in_bit_idx = vecs[i].bi;
      step();
      m_in_valid = 1'b0;
      m_in_data = 16'h5a5a; m_in_sub_idx = 2'd3; m_in_bit_idx = 2'd3;
      chk($sformatf("vec%0d_lat1_valid", i), 32'(m_out_valid), 32'd0);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(m_out_valid), 32'd1);
      chk($sformatf("vec%0d_sub", i), 32'(m_out_sub), 32'(vecs[i].esub));
      chk($sformatf("vec%0d_bit", i), 32'(m_out_bit), 32'(vecs[i].ebit));
      chk($sformatf("vec%0d_err", i), 32'(m_out_err), 32'd0);
    end
    step();

    // Back-to-back with out_ready low for 3 cycles
    begin
      logic [3:0] es[4];
      logic       eb[4];
      int acc = 0, dlv = 0, first = -1, last = -1;
      es = '{4'hd, 4'hc, 4'hb, 4'ha};
      eb = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int cyc = 0; cyc < 20; cyc++) begin
        m_out_ready = (cyc >= 3);
        m_in_valid = (acc < 4);
        m_in_data = 16'habcd; m_in_sub_idx = acc[1:0]; m_in_bit_idx = 2'd0;
        #1;
        if (cyc == 1) chk("bp_in_ready_c1", 32'(m_in_ready), 32'd1);
        if (cyc == 2) chk("bp_in_ready_c2", 32'(m_in_ready), 32'd0);
        if (m_out_valid && m_out_ready) begin
          if (dlv < 4) begin
            chk($sformatf("bp_res%0d_sub", dlv), 32'(m_out_sub), 32'(es[dlv]));
            chk($sformatf("bp_res%0d_bit", dlv), 32'(m_out_bit), 32'(eb[dlv]));
          end
          if (first < 0) first = cyc;
          last = cyc;
          dlv++;
        end
        if (m_in_valid && m_in_ready) acc++;
        step();
      end
      m_in_valid = 1'b0;
      m_out_ready = 1'b1;
      chk("bp_accepted", 32'(acc), 32'd4);
      chk("bp_delivered", 32'(dlv), 32'd4);
      chk("bp_no_bubble", 32'(last - first), 32'd3);
    end

    // Reset with two requests in flight
    m_in_valid = 1'b1; m_in_data = 16'habcd; m_in_sub_idx = 2'd0; m_in_bit_idx = 2'd0;
    step();
    m_in_sub_idx = 2'd1;
    step();
    m_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(m_in_ready), 32'd1);
    chk("mid_rst_out_sub", 32'(m_out_sub), 32'd0);
    step();
    rst = 1'b0;
    m_in_valid = 1'b1; m_in_sub_idx = 2'd1; m_in_bit_idx = 2'd2;
    step();
    m_in_valid = 1'b0;
    chk("post_rst_lat1_valid", 32'(m_out_valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(m_out_valid), 32'd1);
    chk("post_rst_sub", 32'(m_out_sub), 32'hc);
    chk("post_rst_bit", 32'(m_out_bit), 32'd1);
    step();
    chk("post_rst_drained", 32'(m_out_valid), 32'd0);

    // 12/4: sub index 3 is out of range
    run_c("w12_oor", 12'h5a3, 2'd3, 2'd0, 4'h0, 1'b0, ErrEn);
    run_c("w12_s2b3", 12'h5a3, 2'd2, 2'd3, 4'h5, 1'b0, 1'b0);
    run_c("w12_s1b3", 12'h5a3, 2'd1, 2'd3, 4'ha, 1'b1, 1'b0);
    run_c("w12_s0b1", 12'h5a3, 2'd0, 2'd1, 4'h3, 1'b1, 1'b0);

    // 8/1: single-bit sub-words; bit index 1 is out of range
    run_b("w8_s7", 8'h80, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    run_b("w8_s7_bitoor", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0, ErrEn);
    run_b("w8_s6", 8'h80, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
